// File: rtl/sym_dn_lut_loader.sv
// Streams packed LUT words into a 1-bit-wide LUT RAM, one bit per cycle, LSB first.
// All RAM-facing outputs come straight from flops so the RAM sees no input-to-output paths.
module sym_dn_lut_loader #(
  parameter int WORD_W    = 16,
  parameter int LUT_DEPTH = 128
) (
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              lut_in,
  output logic [6:0]        write_addr,
  output logic              we,
  output logic              load_busy,
  output logic              load_done
);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [6:0]        addr_q, addr_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              s_ready_q, s_ready_d;
  logic              we_q, we_d;
  logic              lut_in_q, lut_in_d;
  logic [6:0]        waddr_q, waddr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_bit, last_addr;

  assign last_bit  = (bit_q == BW'(WORD_W - 1));
  assign last_addr = (addr_q == 7'(LUT_DEPTH - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: if (load_start) begin
        state_d = WAIT_WORD;
        addr_d  = '0;
        bit_d   = '0;
      end
      WAIT_WORD: if (s_valid) begin
        shreg_d = s_data;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        // Saturate on the final entry so the counter never wraps inside a load.
        addr_d  = last_addr ? addr_q : addr_q + 7'd1;
        bit_d   = last_bit ? '0 : bit_q + BW'(1);
        if (last_bit) state_d = last_addr ? DONE : WAIT_WORD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they line up with it.
    s_ready_d = (state_d == WAIT_WORD);
    we_d      = (state_d == SHIFT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    lut_in_d  = lut_in_q;
    waddr_d   = waddr_q;
    if (state_d == SHIFT) begin
      lut_in_d = shreg_d[0];
      waddr_d  = addr_d;
    end
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      addr_q    <= '0;
      bit_q     <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      lut_in_q  <= 1'b0;
      waddr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      bit_q     <= bit_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      lut_in_q  <= lut_in_d;
      waddr_q   <= waddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign we         = we_q;
  assign lut_in     = lut_in_q;
  assign write_addr = waddr_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
endmodule

// File: tb/tb_sym_dn_lut_loader.sv
// Directed bench for sym_dn_lut_loader: drives word streams, models the LUT RAM
// from we/write_addr/lut_in and checks timing, sequencing and final contents.
module tb_sym_dn_lut_loader;
  logic        write_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load_start = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, lut_in, we, load_busy, load_done;
  logic [6:0]  write_addr;

  int total = 0;
  int bad = 0;
  logic [15:0] words [8];
  bit          lut [128];
  bit          nom_lut [128];
  int          we_cnt, done_cnt, done_cyc, stall_seen;

  sym_dn_lut_loader #(.WORD_W(16), .LUT_DEPTH(128)) dut (
    .write_clk(write_clk), .rstn(rstn), .load_start(load_start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .lut_in(lut_in),
    .write_addr(write_addr), .we(we), .load_busy(load_busy), .load_done(load_done)
  );

  always #5 write_clk = ~write_clk;

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  function automatic bit exp_bit(input int a);
    logic [15:0] w;
    w = words[a / 16];
    return w[a % 16];
  endfunction

  // Cycle 0 is the cycle load_start is presented; every later value is sampled
  // just after the edge that opens cycle `cyc`. Writes are applied to the LUT
  // model at the edge that ends the cycle they are seen in.
  task automatic run_load(input int stall_len, input int p1, input int p2, input int abort_addr);
    int widx, exp_a;
    widx = 0; exp_a = 0; we_cnt = 0; done_cnt = 0; done_cyc = -1; stall_seen = 0;
    load_start = 1'b1; s_valid = 1'b0; s_data = words[0];
    for (int cyc = 1; cyc < 400; cyc++) begin
      tick();
      load_start = (cyc == p1) || (cyc == p2);
      if (we) begin
        total++;
        if (write_addr !== 7'(exp_a)) begin
          bad++; $display("FAIL addr_seq cyc=%0d got=%0d exp=%0d", cyc, write_addr, exp_a);
        end
        if (abort_addr >= 0 && exp_a == abort_addr) return;
        lut[write_addr] = lut_in;
        we_cnt++; exp_a++;
      end
      if (load_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        total++;
        if (load_busy !== 1'b0) begin
          bad++; $display("FAIL busy_after_done got=%0b exp=0", load_busy);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
      if (widx == 3 && s_ready && stall_seen < stall_len) begin
        s_valid = 1'b0;
        stall_seen++;
        total++;
        if (we !== 1'b0) begin
          bad++; $display("FAIL stall_we cyc=%0d got=%0b exp=0", cyc, we);
        end
      end else begin
        s_valid = (widx < 8);
      end
      s_data = words[(widx < 8) ? widx : 7];
      if (s_ready && s_valid) widx++;
    end
    load_start = 1'b0; s_valid = 1'b0;
    if (abort_addr < 0) begin
      total++;
      if (done_cyc < 0) begin
        bad++; $display("FAIL load_timeout got=no_done exp=done");
      end
    end
  endtask

  task automatic preset_inverse();
    for (int a = 0; a < 128; a++) lut[a] = ~exp_bit(a);
  endtask

  task automatic check_contents(input string name);
    int errs;
    errs = 0;
    for (int a = 0; a < 128; a++) if (lut[a] !== exp_bit(a)) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL %s got=%0d_bad_entries exp=0", name, errs);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({s_ready, we, lut_in, write_addr, load_busy, load_done} !== 12'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0",
                      {s_ready, we, lut_in, write_addr, load_busy, load_done});
    end
    tick();
    rstn = 1'b1;
    s_valid = 1'b1; s_data = 16'hFFFF;
    repeat (5) tick();
    total++;
    if ({s_ready, we, load_busy, load_done} !== 4'h0) begin
      bad++; $display("FAIL idle_after_reset got=%h exp=0", {s_ready, we, load_busy, load_done});
    end
    s_valid = 1'b0;
  endtask

  task automatic test_nominal();
    int errs;
    words = '{16'h0001, 16'h0000, 16'hA5A5, 16'h8000, 16'hFFFE, 16'h5A5A, 16'h00FF, 16'hFFFF};
    preset_inverse();
    run_load(0, -1, -1, -1);
    total++;
    if (done_cyc != 137) begin bad++; $display("FAIL nom_done_cycle got=%0d exp=137", done_cyc); end
    total++;
    if (we_cnt != 128) begin bad++; $display("FAIL nom_we_count got=%0d exp=128", we_cnt); end
    total++;
    if (lut[0] !== 1'b1) begin bad++; $display("FAIL nom_addr0 got=%0b exp=1", lut[0]); end
    errs = 0;
    for (int a = 1; a < 16; a++) if (lut[a] !== 1'b0) errs++;
    for (int a = 112; a < 128; a++) if (lut[a] !== 1'b1) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL nom_ranges got=%0d_bad exp=0", errs); end
    check_contents("nom_contents");
    nom_lut = lut;
  endtask

  task automatic test_stall();
    int errs;
    preset_inverse();
    run_load(5, -1, -1, -1);
    total++;
    if (stall_seen != 5) begin bad++; $display("FAIL stall_len got=%0d exp=5", stall_seen); end
    total++;
    if (done_cyc != 142) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=142", done_cyc); end
    total++;
    if (we_cnt != 128) begin bad++; $display("FAIL stall_we_count got=%0d exp=128", we_cnt); end
    errs = 0;
    for (int a = 0; a < 128; a++) if (lut[a] !== nom_lut[a]) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL stall_vs_nominal got=%0d_bad exp=0", errs); end
  endtask

  task automatic test_ignored_start();
    run_load(0, 10, 137, -1);
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
    total++;
    if (done_cyc != 137) begin bad++; $display("FAIL ign_done_cycle got=%0d exp=137", done_cyc); end
    total++;
    if (load_busy !== 1'b0 || s_ready !== 1'b0) begin
      bad++; $display("FAIL ign_no_restart got=%b%b exp=00", load_busy, s_ready);
    end
    check_contents("ign_contents");
  endtask

  task automatic test_reset_mid_load();
    run_load(0, -1, -1, 69);
    total++;
    if (we !== 1'b1 || write_addr !== 7'h45) begin
      bad++; $display("FAIL abort_point got=%b/%h exp=1/45", we, write_addr);
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({we, write_addr, load_busy, s_ready, load_done} !== 11'h0) begin
      bad++; $display("FAIL midload_reset got=%h exp=0", {we, write_addr, load_busy, s_ready, load_done});
    end
    tick(); tick();
    rstn = 1'b1;
    repeat (3) tick();
    total++;
    if ({we, load_busy} !== 2'b00) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=00", {we, load_busy});
    end
    words = '{16'h8001, 16'h0F0F, 16'h3C3C, 16'h7FFF, 16'hC001, 16'h1111, 16'h2222, 16'h8000};
    preset_inverse();
    run_load(0, -1, -1, -1);
    total++;
    if (we_cnt != 128 || done_cyc != 137) begin
      bad++; $display("FAIL reload got=%0d/%0d exp=128/137", we_cnt, done_cyc);
    end
    check_contents("reload_contents");
  endtask

  task automatic test_readback();
    total++;
    if ({lut[0], lut[63], lut[64], lut[127]} !== 4'b1011) begin
      bad++; $display("FAIL readback got=%b exp=1011", {lut[0], lut[63], lut[64], lut[127]});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    repeat (3) tick();
    test_stall();
    repeat (3) tick();
    test_ignored_start();
    repeat (3) tick();
    test_reset_mid_load();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
